// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath select and write enable.
module multicycle_control_fsm #(
    parameter int OP_WIDTH    = 7,
    parameter int ALUOP_WIDTH = 2,
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   reg_write,
    output logic [1:0]             imm_src,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] state_dbg
);

    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_I    = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(7'b1100011);

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = ALUOP_WIDTH'(2'b00);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = ALUOP_WIDTH'(2'b01);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FN  = ALUOP_WIDTH'(2'b10);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // State-decoded controls; en_* are qualifiers later gated by reset, mem_ready or zero.
    typedef struct packed {
        logic                   adr_src;
        logic [1:0]             result_src;
        logic [1:0]             alu_src_a;
        logic [1:0]             alu_src_b;
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic                   en_fetch;
        logic                   en_mw;
        logic                   en_rw;
        logic                   en_jal;
        logic                   en_beq;
        logic                   is_dec;
    } ctl_t;

    function automatic ctl_t f_dec(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; c.en_fetch = 1'b1; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.is_dec = 1'b1; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB:    begin c.result_src = 2'b01; c.en_rw = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.en_mw = 1'b1; end
            S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = ALU_FN; end
            S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = ALU_FN; end
            S_ALUWB:    c.en_rw = 1'b1;
            S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.en_jal = 1'b1; end
            S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = ALU_SUB; c.en_beq = 1'b1; end
            default:    c = '0;
        endcase
        c.alu_op = (s == S_FETCH || s == S_DECODE) ? ALU_ADD : c.alu_op;
        return c;
    endfunction

    state_t r_state;
    ctl_t   r_ctl;
    state_t w_next;
    logic   w_op_legal;

    always_comb begin
        w_op_legal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: w_op_legal = 1'b1;
            default:                                   w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE :
                                 (op == OP_LW) ? S_MEMREAD  : S_FETCH;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // Controls are registered alongside the state so they never glitch on state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ctl   <= f_dec(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctl   <= f_dec(w_next);
        end
    end

    assign adr_src    = r_ctl.adr_src;
    assign result_src = r_ctl.result_src;
    assign alu_src_a  = r_ctl.alu_src_a;
    assign alu_src_b  = r_ctl.alu_src_b;
    assign alu_op     = r_ctl.alu_op;
    assign state_dbg  = STATE_WIDTH'(r_state);

    // Enables are also qualified by rst_n so they drop the instant reset asserts.
    assign ir_write   = rst_n & r_ctl.en_fetch & mem_ready;
    assign pc_write   = rst_n & ((r_ctl.en_fetch & mem_ready) | r_ctl.en_jal | (r_ctl.en_beq & zero));
    assign mem_write  = rst_n & r_ctl.en_mw;
    assign reg_write  = rst_n & r_ctl.en_rw;
    assign illegal_op = rst_n & r_ctl.is_dec & ~w_op_legal;

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// its state sequence and checks selects/enables against hand-derived values.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_dbg;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .imm_src(imm_src),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
        #2;
        tick(); tick();
        total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
        total++; if ({ir_write, pc_write, mem_write, reg_write, illegal_op} !== 5'b0) begin
            bad++; $display("FAIL rst_enables got=%b exp=00000", {ir_write, pc_write, mem_write, reg_write, illegal_op}); end
        total++; if ({alu_src_a, alu_src_b, result_src, alu_op, adr_src} !== 9'b00_10_10_00_0) begin
            bad++; $display("FAIL rst_selects got=%b exp=001010000", {alu_src_a, alu_src_b, result_src, alu_op, adr_src}); end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        int exp_st[5] = '{0, 1, 6, 7, 0};
        op = 7'b0110011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if (reg_write !== (i == 3)) begin bad++; $display("FAIL rtype_regwrite[%0d] got=%b exp=%b", i, reg_write, i == 3); end
            if (i == 0) begin
                total++; if (ir_write !== 1'b1) begin bad++; $display("FAIL rtype_irwrite got=%b exp=1", ir_write); end
            end
            if (i == 2) begin
                total++; if (alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
                    bad++; $display("FAIL rtype_exec got=%b%b%b exp=101000", alu_op, alu_src_a, alu_src_b); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_lw_wait();
        int   exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        logic mr[8]     = '{1, 1, 1, 0, 0, 1, 1, 1};
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if (adr_src !== (exp_st[i] == 3)) begin bad++; $display("FAIL lw_adrsrc[%0d] got=%b exp=%b", i, adr_src, exp_st[i] == 3); end
            total++; if (reg_write !== (i == 6)) begin bad++; $display("FAIL lw_regwrite[%0d] got=%b exp=%b", i, reg_write, i == 6); end
            if (i == 6) begin
                total++; if (result_src !== 2'b01) begin bad++; $display("FAIL lw_resultsrc got=%b exp=01", result_src); end
            end
            if (i == 2) begin
                total++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin
                    bad++; $display("FAIL lw_memadr got=%b%b exp=1001", alu_src_a, alu_src_b); end
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_beq();
        int exp_st[4] = '{0, 1, 10, 0};
        op = 7'b1100011; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'(z);
            for (int i = 0; i < 4; i++) begin
                #1;
                total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL beq%0d_state[%0d] got=%0d exp=%0d", z, i, state_dbg, exp_st[i]); end
                if (i == 2) begin
                    total++; if (pc_write !== 1'(z)) begin bad++; $display("FAIL beq%0d_pcwrite got=%b exp=%0d", z, pc_write, z); end
                    total++; if (alu_op !== 2'b01) begin bad++; $display("FAIL beq%0d_aluop got=%b exp=01", z, alu_op); end
                    total++; if (imm_src !== 2'b10) begin bad++; $display("FAIL beq%0d_immsrc got=%b exp=10", z, imm_src); end
                end
                if (i < 3) tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        int exp_st[5] = '{0, 1, 9, 7, 0};
        op = 7'b1101111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if (reg_write !== (i == 3)) begin bad++; $display("FAIL jal_regwrite[%0d] got=%b exp=%b", i, reg_write, i == 3); end
            if (i == 2) begin
                total++; if (pc_write !== 1'b1 || imm_src !== 2'b11) begin
                    bad++; $display("FAIL jal_pcw_imm got=%b%b exp=111", pc_write, imm_src); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_sw_wait();
        int   exp_st[8] = '{0, 0, 0, 0, 1, 2, 5, 0};
        logic mr[8]     = '{0, 0, 0, 1, 1, 1, 1, 1};
        op = 7'b0100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if ({ir_write, pc_write} !== {2{(i == 3 || i == 7)}}) begin
                bad++; $display("FAIL sw_irpc[%0d] got=%b%b exp=%b", i, ir_write, pc_write, (i == 3 || i == 7)); end
            total++; if (mem_write !== (i == 6)) begin bad++; $display("FAIL sw_memwrite[%0d] got=%b exp=%b", i, mem_write, i == 6); end
            total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL sw_regwrite[%0d] got=%b exp=0", i, reg_write); end
            if (i == 4) begin
                total++; if (imm_src !== 2'b01) begin bad++; $display("FAIL sw_immsrc got=%b exp=01", imm_src); end
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_illegal();
        int exp_st[3] = '{0, 1, 0};
        op = 7'b1111111; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL ill_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if (illegal_op !== (i == 1)) begin bad++; $display("FAIL ill_pulse[%0d] got=%b exp=%b", i, illegal_op, i == 1); end
            if (i < 2) tick();
        end
    endtask

    task automatic test_reset_mid();
        op = 7'b0100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        total++; if (state_dbg !== 4'd5 || mem_write !== 1'b1) begin
            bad++; $display("FAIL rmid_pre got=%0d/%b exp=5/1", state_dbg, mem_write); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_write !== 1'b0 || state_dbg !== 4'd0) begin
            bad++; $display("FAIL rmid_abort got=%b/%0d exp=0/0", mem_write, state_dbg); end
        tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        total++; if (state_dbg !== 4'd0 || ir_write !== 1'b1) begin
            bad++; $display("FAIL rmid_fetch got=%0d/%b exp=0/1", state_dbg, ir_write); end
        tick();
        total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL rmid_decode got=%0d exp=1", state_dbg); end
        op = 7'b1111111;
        tick();
    endtask

    task automatic test_back_to_back();
        int exp_st[9] = '{0, 1, 8, 7, 0, 1, 8, 7, 0};
        op = 7'b0010011; mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            total++; if (state_dbg !== 4'(exp_st[i])) begin bad++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, state_dbg, exp_st[i]); end
            total++; if (32'(ir_write) + 32'(mem_write) + 32'(reg_write) > 1) begin
                bad++; $display("FAIL b2b_onehot[%0d] got=%b%b%b exp=at most one", i, ir_write, mem_write, reg_write); end
            if (exp_st[i] == 8) begin
                total++; if (alu_src_b !== 2'b01 || alu_op !== 2'b10) begin
                    bad++; $display("FAIL b2b_execi[%0d] got=%b%b exp=0110", i, alu_src_b, alu_op); end
            end
            if (i < 8) tick();
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_jal();
        test_sw_wait();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable.
- Produces the 2-bit alu_op consumed by the downstream ALU decoder (00 add, 01 subtract/compare, 10 decode from funct3/funct7), plus imm_src for the immediate extender.

Parameters:
OP_WIDTH, 7, opcode width
ALUOP_WIDTH, 2, alu_op width (must match ALU decoder)
STATE_WIDTH, 4, state register / debug port width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
op  in  OP_WIDTH  opcode from instruction register (stable except when ir_write fires)
zero  in  1  ALU zero flag
mem_ready  in  1  unified memory completes access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 PC, 1 ALU result register
mem_write  out  1  data memory write enable
ir_write  out  1  instruction/old-PC register enable
result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
alu_src_a  out  2  00 PC, 01 old PC, 10 rs1 data
alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
alu_op  out  ALUOP_WIDTH  to ALU decoder
reg_write  out  1  register file write enable
imm_src  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  STATE_WIDTH  current state encoding

Behaviour:
- Moore FSM; all outputs decode from current state, except:
  - imm_src is purely from op.
  - pc_write uses zero.
  - Memory-state enables are gated by mem_ready.
- Unlisted selects are 00 / 0.
- State encodings (fixed):
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10
- Reset:
  - State goes to FETCH asynchronously.
  - While rst_n=0, pc_write, ir_write, mem_write, reg_write and illegal_op are forced 0.
  - Selects show FETCH values.
- State actions and transitions:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Go to DECODE when mem_ready=1, else hold.
  - DECODE: alu_src_a=01, alu_src_b=10, alu_op=00.
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> FETCH with illegal_op=1 for that cycle
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. op=lw -> MEMREAD, op=sw -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held every cycle while waiting). Go to FETCH on mem_ready.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero -> FETCH.
- imm_src mapping: sw 01, beq 10, jal 11, all others 00.
- Latency with zero-wait memory:
  - lw 5 cycles
  - sw, R-type, I-type 4 cycles
  - jal 4 cycles
  - beq 3 cycles
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
- At most one of reg_write/mem_write/ir_write is high in any cycle.
- Reset asserted mid-instruction aborts it: no further enables, and FETCH begins on the first clk after rst_n rises.
- The FSM never reaches an undefined encoding; any unused state (11-15) goes to FETCH next cycle with all enables 0.

Test Plan:
- Reset then rst_n=1, mem_ready=1, op=0110011 -> state_dbg 0,1,6,7,0. ir_write=1 in cycle 0; alu_op=10 in state 6; reg_write=1 only in state 7.
- op=0000011, mem_ready held 0 for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0. adr_src=1 throughout state 3; reg_write with result_src=01 in state 4.
- op=1100011 with zero=1, then repeat with zero=0 -> pc_write=1 in BEQ with alu_op=01 for zero=1; pc_write=0 for zero=0; imm_src=10 in both.
- op=1101111 -> states 0,1,9,7,0. pc_write=1 in state 9, imm_src=11, reg_write=1 in state 7.
- op=0100011, mem_ready=0 in FETCH for 3 cycles -> ir_write/pc_write stay 0 until mem_ready=1. mem_write=1 in state 5; reg_write never asserts.
- op=1111111 -> illegal_op pulses exactly once in DECODE, next state FETCH. Separately, assert rst_n=0 during MEMWRITE -> mem_write drops immediately, state_dbg=0.
